// File: rtl/mipi_host_read_requester.sv
// Host-side DSI read initiator: optional MRPS, read short packet with BTA, response capture.
// Latency: rd_done one cycle after a short header or after the final long-payload word.
// Backpressure: tx_cmd_req is held with stable cmd/bta until tx_cmd_ack; rx side has no backpressure.
module mipi_host_read_requester #(
  parameter int          MAX_BYTES      = 16,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd1000000,
  parameter logic [1:0]  VC             = 2'd0
) (
  input  logic                   clk_host,
  input  logic                   rstn,
  input  logic                   rd_start,
  input  logic                   rd_dcs,
  input  logic [7:0]             rd_addr,
  input  logic [15:0]            rd_max_len,
  output logic                   rd_busy,
  output logic                   rd_done,
  output logic [1:0]             rd_status,
  output logic [15:0]            rd_len,
  output logic                   rd_trunc,
  output logic [8*MAX_BYTES-1:0] rd_data,
  output logic [23:0]            mipi_host_tx_cmd,
  output logic                   mipi_host_tx_cmd_bta,
  output logic                   mipi_host_tx_cmd_req,
  input  logic                   mipi_host_tx_cmd_ack,
  input  logic                   mipi_host_dphy_direction,
  input  logic [23:0]            mipi_host_rx_cmd,
  input  logic                   mipi_host_rx_cmd_valid,
  input  logic [31:0]            mipi_host_rx_payload,
  input  logic                   mipi_host_rx_payload_valid
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND_MRPS = 3'd1,
    ST_SEND_RD   = 3'd2,
    ST_WAIT_RESP = 3'd3,
    ST_RX_LONG   = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  localparam logic [15:0] LP_MAX_BYTES = 16'(MAX_BYTES);
  localparam logic [19:0] LP_TMO_LAST  = TIMEOUT_CYCLES - 20'd1;

  state_t                 r_state;
  logic                   r_dcs;
  logic [7:0]             r_addr;
  logic [15:0]            r_max_len;
  logic                   r_mrps_valid;
  logic [15:0]            r_mrps_last;
  logic                   r_busy;
  logic                   r_done;
  logic [1:0]             r_status;
  logic [15:0]            r_len;
  logic                   r_trunc;
  logic [8*MAX_BYTES-1:0] r_data;
  logic [23:0]            r_tx_cmd;
  logic                   r_bta;
  logic                   r_req;
  logic                   r_dir_q;
  logic                   r_dir_seen;
  logic [19:0]            r_tmo_cnt;
  logic [15:0]            r_wc;
  logic [15:0]            r_words_needed;
  logic [15:0]            r_word_cnt;

  logic [5:0]  w_dt;
  logic [7:0]  w_d0;
  logic [7:0]  w_d1;
  logic [15:0] w_wc;
  logic [15:0] w_wc_words;
  logic [1:0]  w_unused_rx_vc;
  logic        w_dir_rise;
  logic        w_hdr_ok;
  logic        w_tmo;
  logic        w_last_word;
  logic        w_need_mrps;

  assign w_dt           = mipi_host_rx_cmd[5:0];
  assign w_d0           = mipi_host_rx_cmd[15:8];
  assign w_d1           = mipi_host_rx_cmd[23:16];
  assign w_wc           = {w_d1, w_d0};
  assign w_wc_words     = 16'((17'(w_wc) + 17'd3) >> 2);
  assign w_unused_rx_vc = mipi_host_rx_cmd[7:6];
  // Only the direction rising edge (or a header after it) arms header capture.
  assign w_dir_rise     = mipi_host_dphy_direction & ~r_dir_q;
  assign w_hdr_ok       = mipi_host_rx_cmd_valid & (r_dir_seen | w_dir_rise);
  assign w_tmo          = (r_tmo_cnt == LP_TMO_LAST);
  assign w_last_word    = (r_word_cnt == (r_words_needed - 16'd1));
  // MRPS is skipped when the peripheral already holds the same limit.
  assign w_need_mrps    = (rd_max_len != 16'd0) &&
                          !(r_mrps_valid && (rd_max_len == r_mrps_last));

  assign rd_busy              = r_busy;
  assign rd_done              = r_done;
  assign rd_status            = r_status;
  assign rd_len               = r_len;
  assign rd_trunc             = r_trunc;
  assign rd_data              = r_data;
  assign mipi_host_tx_cmd     = r_tx_cmd;
  assign mipi_host_tx_cmd_bta = r_bta;
  assign mipi_host_tx_cmd_req = r_req;

  // Read-transaction FSM with all outputs registered.
  always_ff @(posedge clk_host) begin
    if (!rstn) begin
      r_state        <= ST_IDLE;
      r_dcs          <= 1'b0;
      r_addr         <= 8'd0;
      r_max_len      <= 16'd0;
      r_mrps_valid   <= 1'b0;
      r_mrps_last    <= 16'd0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_status       <= 2'd0;
      r_len          <= 16'd0;
      r_trunc        <= 1'b0;
      r_data         <= '0;
      r_tx_cmd       <= 24'd0;
      r_bta          <= 1'b0;
      r_req          <= 1'b0;
      r_dir_q        <= 1'b0;
      r_dir_seen     <= 1'b0;
      r_tmo_cnt      <= 20'd0;
      r_wc           <= 16'd0;
      r_words_needed <= 16'd0;
      r_word_cnt     <= 16'd0;
    end else begin
      r_dir_q <= mipi_host_dphy_direction;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (rd_start) begin
            r_dcs     <= rd_dcs;
            r_addr    <= rd_addr;
            r_max_len <= rd_max_len;
            r_data    <= '0;
            r_len     <= 16'd0;
            r_trunc   <= 1'b0;
            r_status  <= 2'd0;
            r_busy    <= 1'b1;
            r_state   <= w_need_mrps ? ST_SEND_MRPS : ST_SEND_RD;
          end
        end

        ST_SEND_MRPS: begin
          if (!r_req) begin
            r_req    <= 1'b1;
            r_tx_cmd <= {r_max_len[15:8], r_max_len[7:0], VC, 6'h37};
            r_bta    <= 1'b0;
          end else if (mipi_host_tx_cmd_ack) begin
            r_req        <= 1'b0;
            r_mrps_valid <= 1'b1;
            r_mrps_last  <= r_max_len;
            r_state      <= ST_SEND_RD;
          end
        end

        ST_SEND_RD: begin
          if (!r_req) begin
            r_req    <= 1'b1;
            r_tx_cmd <= {8'h00, r_addr, VC, (r_dcs ? 6'h06 : 6'h14)};
            r_bta    <= 1'b1;
          end else if (mipi_host_tx_cmd_ack) begin
            r_req      <= 1'b0;
            r_tmo_cnt  <= 20'd0;
            r_dir_seen <= 1'b0;
            r_state    <= ST_WAIT_RESP;
          end
        end

        ST_WAIT_RESP: begin
          r_tmo_cnt <= r_tmo_cnt + 20'd1;
          if (w_dir_rise) r_dir_seen <= 1'b1;
          if (w_hdr_ok) begin
            case (w_dt)
              6'h21, 6'h11: begin
                r_data[7:0] <= w_d0;
                r_len       <= 16'd1;
                r_done      <= 1'b1;
                r_state     <= ST_DONE;
              end
              6'h22, 6'h12: begin
                r_data[15:0] <= {w_d1, w_d0};
                r_len        <= 16'd2;
                r_done       <= 1'b1;
                r_state      <= ST_DONE;
              end
              6'h1C, 6'h1A: begin
                r_len          <= w_wc;
                r_wc           <= w_wc;
                r_trunc        <= (w_wc > LP_MAX_BYTES);
                r_words_needed <= w_wc_words;
                r_word_cnt     <= 16'd0;
                if (w_wc == 16'd0) begin
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
                end else begin
                  r_state <= ST_RX_LONG;
                end
              end
              6'h02: begin
                r_data[15:0] <= {w_d1, w_d0};
                r_len        <= 16'd2;
                r_status     <= 2'd1;
                r_done       <= 1'b1;
                r_state      <= ST_DONE;
              end
              default: begin
                r_status <= 2'd3;
                r_done   <= 1'b1;
                r_state  <= ST_DONE;
              end
            endcase
          end else if (w_tmo) begin
            r_status <= 2'd2;
            r_done   <= 1'b1;
            r_state  <= ST_DONE;
          end
        end

        ST_RX_LONG: begin
          r_tmo_cnt <= r_tmo_cnt + 20'd1;
          if (mipi_host_rx_payload_valid) begin
            // Word k lands in bytes 4k..4k+3; bytes past WC stay zero.
            for (int b = 0; b < MAX_BYTES; b++) begin
              if ((r_word_cnt == 16'(b / 4)) && (16'(b) < r_wc)) begin
                r_data[b*8 +: 8] <= mipi_host_rx_payload[(b % 4)*8 +: 8];
              end
            end
            r_word_cnt <= r_word_cnt + 16'd1;
          end
          if (mipi_host_rx_payload_valid && w_last_word) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else if (w_tmo) begin
            r_status <= 2'd2;
            r_done   <= 1'b1;
            r_state  <= ST_DONE;
          end
        end

        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mipi_host_read_requester.sv
// Self-checking bench for mipi_host_read_requester: directed cases then randomized reads.
// Latency: checks rd_done timing relative to header / final word / read ack.
// Backpressure: bench acks tx requests after a random hold; rx side is bench-driven.
module tb_mipi_host_read_requester;

  localparam int          MB  = 16;
  localparam logic [19:0] TMO = 20'd100;
  localparam logic [1:0]  VCH = 2'd1;

  logic            clk_host = 1'b0;
  logic            rstn;
  logic            rd_start;
  logic            rd_dcs;
  logic [7:0]      rd_addr;
  logic [15:0]     rd_max_len;
  logic            rd_busy;
  logic            rd_done;
  logic [1:0]      rd_status;
  logic [15:0]     rd_len;
  logic            rd_trunc;
  logic [8*MB-1:0] rd_data;
  logic [23:0]     mipi_host_tx_cmd;
  logic            mipi_host_tx_cmd_bta;
  logic            mipi_host_tx_cmd_req;
  logic            mipi_host_tx_cmd_ack;
  logic            mipi_host_dphy_direction;
  logic [23:0]     mipi_host_rx_cmd;
  logic            mipi_host_rx_cmd_valid;
  logic [31:0]     mipi_host_rx_payload;
  logic            mipi_host_rx_payload_valid;

  mipi_host_read_requester #(
    .MAX_BYTES(MB), .TIMEOUT_CYCLES(TMO), .VC(VCH)
  ) dut (
    .clk_host(clk_host), .rstn(rstn),
    .rd_start(rd_start), .rd_dcs(rd_dcs), .rd_addr(rd_addr), .rd_max_len(rd_max_len),
    .rd_busy(rd_busy), .rd_done(rd_done), .rd_status(rd_status), .rd_len(rd_len),
    .rd_trunc(rd_trunc), .rd_data(rd_data),
    .mipi_host_tx_cmd(mipi_host_tx_cmd), .mipi_host_tx_cmd_bta(mipi_host_tx_cmd_bta),
    .mipi_host_tx_cmd_req(mipi_host_tx_cmd_req), .mipi_host_tx_cmd_ack(mipi_host_tx_cmd_ack),
    .mipi_host_dphy_direction(mipi_host_dphy_direction),
    .mipi_host_rx_cmd(mipi_host_rx_cmd), .mipi_host_rx_cmd_valid(mipi_host_rx_cmd_valid),
    .mipi_host_rx_payload(mipi_host_rx_payload),
    .mipi_host_rx_payload_valid(mipi_host_rx_payload_valid)
  );

  always #5 clk_host = ~clk_host;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state: what the peripheral currently believes the return limit is.
  logic        m_mrps_valid;
  logic [15:0] m_mrps_last;
  logic [7:0]  pbytes [0:63];

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_host);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_rd(input logic dcs, input logic [7:0] addr, input logic [15:0] ml);
    rd_dcs = dcs; rd_addr = addr; rd_max_len = ml; rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
  endtask

  task automatic tx_hs(input string tag, input logic [23:0] cmd, input logic bta);
    int n;
    n = 0;
    while (!mipi_host_tx_cmd_req && n < 50) begin tick(); n++; end
    chk({tag, "_req"}, 128'(mipi_host_tx_cmd_req), 128'(1'b1));
    chk({tag, "_cmd"}, 128'({mipi_host_tx_cmd, mipi_host_tx_cmd_bta}), 128'({cmd, bta}));
    repeat ($urandom_range(0, 2)) begin
      tick();
      chk({tag, "_hold"}, 128'({mipi_host_tx_cmd_req, mipi_host_tx_cmd, mipi_host_tx_cmd_bta}),
          128'({1'b1, cmd, bta}));
    end
    mipi_host_tx_cmd_ack = 1'b1;
    tick();
    mipi_host_tx_cmd_ack = 1'b0;
    chk({tag, "_drop"}, 128'(mipi_host_tx_cmd_req), 128'(1'b0));
  endtask

  // Expected packet sequence derived from the MRPS rule and the read packet format.
  task automatic issue(input logic dcs, input logic [7:0] addr, input logic [15:0] ml);
    start_rd(dcs, addr, ml);
    chk("busy_rise", 128'(rd_busy), 128'(1'b1));
    if (ml != 16'd0 && !(m_mrps_valid && m_mrps_last == ml)) begin
      tx_hs("mrps", {ml, VCH, 6'h37}, 1'b0);
      m_mrps_valid = 1'b1;
      m_mrps_last  = ml;
    end
    tx_hs("read", {8'h00, addr, VCH, (dcs ? 6'h06 : 6'h14)}, 1'b1);
  endtask

  task automatic rise_dir(input logic junk);
    if (junk) begin
      mipi_host_rx_cmd = {8'h77, 8'h66, VCH, 6'h21};
      mipi_host_rx_cmd_valid = 1'b1;
      tick();
      mipi_host_rx_cmd_valid = 1'b0;
    end
    repeat ($urandom_range(0, 3)) tick();
    mipi_host_dphy_direction = 1'b1;
    tick();
  endtask

  task automatic send_hdr(input logic [5:0] dt, input logic [7:0] d0, input logic [7:0] d1);
    mipi_host_rx_cmd = {d1, d0, VCH, dt};
    mipi_host_rx_cmd_valid = 1'b1;
    tick();
    mipi_host_rx_cmd_valid = 1'b0;
  endtask

  task automatic send_long(input logic [15:0] wc, input logic gaps);
    int nw;
    nw = (int'(wc) + 3) / 4;
    for (int k = 0; k < nw; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      mipi_host_rx_payload = {pbytes[4*k+3], pbytes[4*k+2], pbytes[4*k+1], pbytes[4*k]};
      mipi_host_rx_payload_valid = 1'b1;
      tick();
      mipi_host_rx_payload_valid = 1'b0;
    end
  endtask

  function automatic logic [127:0] exp_long(input logic [15:0] wc);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < MB; i++) if (i < int'(wc)) v[i*8 +: 8] = pbytes[i];
    return v;
  endfunction

  task automatic fill_pbytes();
    for (int i = 0; i < 64; i++) pbytes[i] = 8'($urandom);
  endtask

  // Called when rd_done should be high right now.
  task automatic check_result(input string tag, input logic [1:0] st, input logic [15:0] len,
                              input logic tr, input logic [127:0] dat);
    chk({tag, "_done"}, 128'(rd_done), 128'(1'b1));
    chk({tag, "_stat"}, 128'({rd_status, rd_len, rd_trunc}), 128'({st, len, tr}));
    chk({tag, "_data"}, rd_data, dat);
    tick();
    chk({tag, "_end"}, 128'({rd_done, rd_busy}), 128'(2'b00));
    mipi_host_dphy_direction = 1'b0;
    tick();
  endtask

  initial begin
    logic        r_dcs;
    logic [7:0]  r_addr, r_d0, r_d1;
    logic [15:0] r_ml, r_wc;
    logic [5:0]  r_dt;
    int          kind, n;
    logic [15:0] ml_set [0:3];

    ml_set[0] = 16'd0; ml_set[1] = 16'd1; ml_set[2] = 16'd2; ml_set[3] = 16'd5;
    rstn = 1'b0; rd_start = 1'b0; rd_dcs = 1'b0; rd_addr = 8'd0; rd_max_len = 16'd0;
    mipi_host_tx_cmd_ack = 1'b0; mipi_host_dphy_direction = 1'b0;
    mipi_host_rx_cmd = 24'd0; mipi_host_rx_cmd_valid = 1'b0;
    mipi_host_rx_payload = 32'd0; mipi_host_rx_payload_valid = 1'b0;
    m_mrps_valid = 1'b0; m_mrps_last = 16'd0;
    for (int i = 0; i < 64; i++) pbytes[i] = 8'd0;

    repeat (3) tick();
    rstn = 1'b1;
    tick();
    chk("rst_ctl", 128'({rd_busy, rd_done, rd_status, rd_len, rd_trunc}), 128'(0));
    chk("rst_data", rd_data, 128'(0));
    chk("rst_tx", 128'({mipi_host_tx_cmd, mipi_host_tx_cmd_bta, mipi_host_tx_cmd_req}), 128'(0));

    // DCS read with MRPS, 1-byte short response.
    issue(1'b1, 8'hDA, 16'd1);
    rise_dir(1'b0);
    send_hdr(6'h21, 8'h5E, 8'h00);
    check_result("dcs1", 2'd0, 16'd1, 1'b0, 128'h5E);

    // Same max_len: MRPS skipped; 2-byte short response.
    issue(1'b1, 8'hDB, 16'd1);
    rise_dir(1'b1);
    send_hdr(6'h22, 8'h31, 8'h12);
    check_result("dcs2", 2'd0, 16'd2, 1'b0, 128'h1231);

    // Generic read, long WC=3.
    issue(1'b0, 8'hBF, 16'd3);
    rise_dir(1'b0);
    pbytes[0] = 8'hAA; pbytes[1] = 8'hBB; pbytes[2] = 8'hCC; pbytes[3] = 8'h00;
    send_hdr(6'h1C, 8'd3, 8'd0);
    send_long(16'd3, 1'b0);
    check_result("long3", 2'd0, 16'd3, 1'b0, 128'hCCBBAA);

    // Long WC=20 overflows the 16-byte buffer.
    issue(1'b0, 8'hBF, 16'd20);
    rise_dir(1'b0);
    fill_pbytes();
    send_hdr(6'h1C, 8'd20, 8'd0);
    send_long(16'd20, 1'b1);
    check_result("long20", 2'd0, 16'd20, 1'b1, exp_long(16'd20));

    // Acknowledge-and-error report, then an unexpected data type.
    issue(1'b1, 8'h0A, 16'd20);
    rise_dir(1'b0);
    send_hdr(6'h02, 8'h00, 8'h01);
    check_result("aer", 2'd1, 16'd2, 1'b0, 128'h0100);
    issue(1'b1, 8'h0B, 16'd20);
    rise_dir(1'b0);
    send_hdr(6'h08, 8'h55, 8'hAA);
    check_result("baddt", 2'd3, 16'd0, 1'b0, 128'h0);

    // No response: timeout exactly TMO cycles after the read ack edge.
    issue(1'b1, 8'h0C, 16'd20);
    n = 0;
    while (!rd_done && n < 150) begin tick(); n++; end
    chk("tmo_cycles", 128'(n), 128'(int'(TMO)));
    check_result("tmo", 2'd2, 16'd0, 1'b0, 128'h0);

    // Reset during RX_LONG: everything clears, no rd_done, MRPS state forgotten.
    issue(1'b0, 8'h44, 16'd20);
    rise_dir(1'b0);
    fill_pbytes();
    send_hdr(6'h1A, 8'd8, 8'd0);
    send_long(16'd4, 1'b0);
    rstn = 1'b0;
    tick();
    mipi_host_dphy_direction = 1'b0;
    rstn = 1'b1;
    m_mrps_valid = 1'b0;
    chk("rstmid_ctl", 128'({rd_busy, rd_done, rd_status, rd_len, rd_trunc}), 128'(0));
    chk("rstmid_data", rd_data, 128'(0));
    chk("rstmid_tx", 128'({mipi_host_tx_cmd, mipi_host_tx_cmd_bta, mipi_host_tx_cmd_req}), 128'(0));
    n = 0;
    repeat (5) begin tick(); if (rd_done) n++; end
    chk("rstmid_nodone", 128'(n), 128'(0));

    // rd_start while busy must not disturb the latched request.
    start_rd(1'b1, 8'hA5, 16'd4);
    chk("busy2", 128'(rd_busy), 128'(1'b1));
    start_rd(1'b0, 8'h3C, 16'd9);
    tx_hs("mrps_b", {16'd4, VCH, 6'h37}, 1'b0);
    m_mrps_valid = 1'b1; m_mrps_last = 16'd4;
    tx_hs("read_b", {8'h00, 8'hA5, VCH, 6'h06}, 1'b1);
    rise_dir(1'b0);
    send_hdr(6'h11, 8'h9C, 8'h00);
    check_result("midbusy", 2'd0, 16'd1, 1'b0, 128'h9C);

    // Randomized reads against the model.
    for (int t = 0; t < 24; t++) begin
      r_dcs  = 1'($urandom_range(0, 1));
      r_addr = 8'($urandom);
      r_ml   = ml_set[$urandom_range(0, 3)];
      r_d0   = 8'($urandom);
      r_d1   = 8'($urandom);
      kind   = $urandom_range(0, 4);
      issue(r_dcs, r_addr, r_ml);
      rise_dir(1'($urandom_range(0, 1)));
      case (kind)
        0: begin
          send_hdr($urandom_range(0, 1) ? 6'h21 : 6'h11, r_d0, r_d1);
          check_result("r_s1", 2'd0, 16'd1, 1'b0, 128'(r_d0));
        end
        1: begin
          send_hdr($urandom_range(0, 1) ? 6'h22 : 6'h12, r_d0, r_d1);
          check_result("r_s2", 2'd0, 16'd2, 1'b0, 128'({r_d1, r_d0}));
        end
        2: begin
          r_wc = 16'($urandom_range(0, 24));
          fill_pbytes();
          send_hdr($urandom_range(0, 1) ? 6'h1C : 6'h1A, r_wc[7:0], r_wc[15:8]);
          send_long(r_wc, 1'b1);
          check_result("r_long", 2'd0, r_wc, (r_wc > 16'(MB)), exp_long(r_wc));
        end
        3: begin
          send_hdr(6'h02, r_d0, r_d1);
          check_result("r_aer", 2'd1, 16'd2, 1'b0, 128'({r_d1, r_d0}));
        end
        default: begin
          r_dt = 6'($urandom);
          while (r_dt == 6'h21 || r_dt == 6'h11 || r_dt == 6'h22 || r_dt == 6'h12 ||
                 r_dt == 6'h1C || r_dt == 6'h1A || r_dt == 6'h02) r_dt = 6'($urandom);
          send_hdr(r_dt, r_d0, r_d1);
          check_result("r_bad", 2'd3, 16'd0, 1'b0, 128'h0);
        end
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
